// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the EX-stage branch controller: condition codes,
// FSM states and the per-op resolution record.
package br_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } br_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        is_link;
    logic        mispredict;
    logic        misaligned;
  } br_resolve_t;

  // JALR clears bit 0 of the computed address before it is used as a target.
  function automatic logic [31:0] jalr_target(input logic [31:0] rs1,
                                              input logic [31:0] imm);
    logic [31:0] sum;
    sum = rs1 + imm;
    return {sum[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle of the op handshake from ID/EX and the redirect/flush/link/exception
// signals towards fetch and writeback.
interface branch_ctrl_if;

  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_funct3;
  logic        br_is_jal;
  logic        br_is_jalr;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic        br_pred_taken;

  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush_ifid;

  logic        link_valid;
  logic [31:0] link_data;
  logic        misalign_exc;
  logic [31:0] exc_pc;

  modport slave (
    input  br_valid, br_funct3, br_is_jal, br_is_jalr, br_pc, br_imm,
           br_rs1, br_rs2, br_pred_taken, redir_ready,
    output br_ready, redir_valid, redir_pc, flush_ifid,
           link_valid, link_data, misalign_exc, exc_pc
  );

  modport master (
    output br_valid, br_funct3, br_is_jal, br_is_jalr, br_pc, br_imm,
           br_rs1, br_rs2, br_pred_taken, redir_ready,
    input  br_ready, redir_valid, redir_pc, flush_ifid,
           link_valid, link_data, misalign_exc, exc_pc
  );

endinterface

// File: rtl/branch_ctrl_branch_unit.sv
// Combinational branch condition evaluator; unknown funct3 codes resolve
// to not-taken.
module branch_unit
  import br_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        take_branch
);

  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      BR_BEQ:  take_branch = (rs1 == rs2);
      BR_BNE:  take_branch = (rs1 != rs2);
      BR_BLT:  take_branch = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  take_branch = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: take_branch = (rs1 <  rs2);
      BR_BGEU: take_branch = (rs1 >= rs2);
      default: take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch/jump resolution: registers the outcome of each accepted op
// and sequences the redirect handshake and IF/ID flush towards fetch.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  br_state_e        state_q,        state_d;
  logic [FC_W-1:0]  flush_cnt_q,    flush_cnt_d;
  logic [31:0]      redir_pc_q,     redir_pc_d;
  logic             link_valid_q,   link_valid_d;
  logic [31:0]      link_data_q,    link_data_d;
  logic             misalign_q,     misalign_d;
  logic [31:0]      exc_pc_q,       exc_pc_d;
  logic [CNT_W-1:0] br_count_q,     br_count_d;
  logic [CNT_W-1:0] mispred_q,      mispred_d;

  logic        take_branch;
  logic        accept;
  br_resolve_t res;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  branch_unit u_branch_unit (
    .funct3      (bus.br_funct3),
    .rs1         (bus.br_rs1),
    .rs2         (bus.br_rs2),
    .take_branch (take_branch)
  );

  // Resolution of the op currently on the inputs; only consumed on accept.
  always_comb begin
    res            = '0;
    res.is_link    = bus.br_is_jal | bus.br_is_jalr;
    res.taken      = res.is_link | take_branch;
    res.pc_plus4   = bus.br_pc + 32'd4;
    res.target     = bus.br_is_jalr ? jalr_target(bus.br_rs1, bus.br_imm)
                                    : bus.br_pc + bus.br_imm;
    res.misaligned = res.taken & (res.target[1:0] != 2'b00);
    if (bus.br_is_jalr)
      res.mispredict = 1'b1;
    else if (bus.br_is_jal)
      res.mispredict = ~bus.br_pred_taken;
    else
      res.mispredict = (res.taken != bus.br_pred_taken);
  end

  assign accept = bus.br_valid & (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    redir_pc_d   = redir_pc_q;
    link_valid_d = 1'b0;
    link_data_d  = '0;
    misalign_d   = 1'b0;
    exc_pc_d     = '0;
    br_count_d   = br_count_q;
    mispred_d    = mispred_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          br_count_d = sat_inc(br_count_q);
          // A misaligned taken target raises an exception instead of redirecting.
          if (res.misaligned) begin
            misalign_d = 1'b1;
            exc_pc_d   = bus.br_pc;
          end else begin
            if (res.is_link) begin
              link_valid_d = 1'b1;
              link_data_d  = res.pc_plus4;
            end
            if (res.mispredict) begin
              redir_pc_d = res.taken ? res.target : res.pc_plus4;
              state_d    = S_REDIRECT;
            end
          end
        end
      end

      S_REDIRECT: begin
        if (bus.redir_ready) begin
          mispred_d = sat_inc(mispred_q);
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES);
          end
        end
      end

      S_FLUSH: begin
        if (flush_cnt_q <= FC_W'(1)) begin
          state_d     = S_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flush_cnt_q  <= '0;
      redir_pc_q   <= '0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      misalign_q   <= 1'b0;
      exc_pc_q     <= '0;
      br_count_q   <= '0;
      mispred_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      redir_pc_q   <= redir_pc_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      misalign_q   <= misalign_d;
      exc_pc_q     <= exc_pc_d;
      br_count_q   <= br_count_d;
      mispred_q    <= mispred_d;
    end
  end

  assign bus.br_ready     = (state_q == S_IDLE);
  assign bus.redir_valid  = (state_q == S_REDIRECT);
  assign bus.flush_ifid   = (state_q == S_REDIRECT) | (state_q == S_FLUSH);
  assign bus.redir_pc     = redir_pc_q;
  assign bus.link_valid   = link_valid_q;
  assign bus.link_data    = link_data_q;
  assign bus.misalign_exc = misalign_q;
  assign bus.exc_pc       = exc_pc_q;
  assign br_count         = br_count_q;
  assign mispred_count    = mispred_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: a scoreboard of expected per-op outcomes
// plus a small-counter, zero-flush instance for saturation and bypass paths.
module tb_branch_ctrl;
  import br_pkg::*;

  localparam int FLUSH = 1;

  typedef struct {
    logic        redir;
    logic [31:0] redir_pc;
    logic        link;
    logic [31:0] link_data;
    logic        exc;
    logic [31:0] exc_pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] br_count, mispred_count;
  logic [1:0]  s_br_count, s_mispred_count;

  int   checks;
  int   errors;
  int   exp_br;
  int   exp_mp;
  exp_t exp_q[$];
  exp_t e;
  logic [1:0] sat_q[$];
  logic [1:0] sat_e;

  branch_ctrl_if bus ();
  branch_ctrl_if bus_s ();

  branch_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s),
    .br_count(s_br_count), .mispred_count(s_mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Independent reference for the registered outcome of one op.
  function automatic exp_t model(input logic [2:0] f3, input logic jal, input logic jalr,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic pred);
    exp_t r;
    logic tk, mp;
    logic [31:0] tgt;
    r = '{redir: 1'b0, redir_pc: 32'h0, link: 1'b0, link_data: 32'h0, exc: 1'b0, exc_pc: 32'h0};
    case (f3)
      3'b000:  tk = (rs1 == rs2);
      3'b001:  tk = (rs1 != rs2);
      3'b100:  tk = ($signed(rs1) < $signed(rs2));
      3'b101:  tk = !($signed(rs1) < $signed(rs2));
      3'b110:  tk = (rs1 < rs2);
      3'b111:  tk = !(rs1 < rs2);
      default: tk = 1'b0;
    endcase
    if (jal || jalr) tk = 1'b1;
    tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    if (tk && (tgt[1:0] != 2'b00)) begin
      r.exc    = 1'b1;
      r.exc_pc = pc;
      return r;
    end
    if (jalr)     mp = 1'b1;
    else if (jal) mp = !pred;
    else          mp = (tk != pred);
    r.link      = jal || jalr;
    r.link_data = pc + 32'd4;
    r.redir     = mp;
    r.redir_pc  = tk ? tgt : pc + 32'd4;
    return r;
  endfunction

  task automatic drive_op(input logic [2:0] f3, input logic jal, input logic jalr,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
    bus.br_funct3     = f3;
    bus.br_is_jal     = jal;
    bus.br_is_jalr    = jalr;
    bus.br_pc         = pc;
    bus.br_imm        = imm;
    bus.br_rs1        = rs1;
    bus.br_rs2        = rs2;
    bus.br_pred_taken = pred;
    bus.br_valid      = 1'b1;
    exp_q.push_back(model(f3, jal, jalr, pc, imm, rs1, rs2, pred));
    exp_br++;
    @(posedge clk);
    @(negedge clk);
    bus.br_valid = 1'b0;
  endtask

  task automatic finish_redirect();
    bus.redir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.redir_ready = 1'b0;
    exp_mp++;
    repeat (FLUSH) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_br_ready: got %b exp 1", bus.br_ready); end
    checks++; if (bus.redir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_redir_valid: got %b exp 0", bus.redir_valid); end
    checks++; if (bus.flush_ifid !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %b exp 0", bus.flush_ifid); end
    checks++; if (bus.link_valid !== 1'b0 || bus.misalign_exc !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got link=%b exc=%b exp 0/0", bus.link_valid, bus.misalign_exc); end
    checks++; if (bus.redir_pc !== 32'h0 || bus.link_data !== 32'h0 || bus.exc_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got redir_pc=%h link=%h exc_pc=%h exp 0", bus.redir_pc, bus.link_data, bus.exc_pc); end
    checks++; if (br_count !== 16'h0 || mispred_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d exp 0/0", br_count, mispred_count); end
    checks++; if (bus_s.br_ready !== 1'b1 || s_br_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_small: got ready=%b cnt=%0d exp 1/0", bus_s.br_ready, s_br_count); end
  endtask

  task automatic test_beq_mispredict();
    drive_op(BR_BEQ, 1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir) begin errors++; $display("[TB] FAIL beq_redir_valid: got %b exp %b", bus.redir_valid, e.redir); end
    checks++; if (bus.redir_pc !== e.redir_pc) begin errors++; $display("[TB] FAIL beq_redir_pc: got %h exp %h", bus.redir_pc, e.redir_pc); end
    checks++; if (bus.flush_ifid !== 1'b1 || bus.br_ready !== 1'b0) begin errors++; $display("[TB] FAIL beq_flush_ready: got flush=%b ready=%b exp 1/0", bus.flush_ifid, bus.br_ready); end
    checks++; if (bus.link_valid !== e.link) begin errors++; $display("[TB] FAIL beq_link: got %b exp %b", bus.link_valid, e.link); end
    bus.redir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.redir_ready = 1'b0;
    exp_mp++;
    checks++; if (mispred_count !== 16'(exp_mp)) begin errors++; $display("[TB] FAIL beq_mispred_count: got %0d exp %0d", mispred_count, exp_mp); end
    checks++; if (bus.redir_valid !== 1'b0 || bus.flush_ifid !== 1'b1) begin errors++; $display("[TB] FAIL beq_flush_state: got redir=%b flush=%b exp 0/1", bus.redir_valid, bus.flush_ifid); end
    @(negedge clk);
    checks++; if (bus.br_ready !== 1'b1 || bus.flush_ifid !== 1'b0) begin errors++; $display("[TB] FAIL beq_back_idle: got ready=%b flush=%b exp 1/0", bus.br_ready, bus.flush_ifid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_op(BR_BNE, 1'b0, 1'b0, 32'h100, 32'h10, 32'd7, 32'd7, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir || bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got redir=%b ready=%b exp %b/1", bus.redir_valid, bus.br_ready, e.redir); end
    checks++; if (br_count !== 16'(exp_br) || mispred_count !== 16'(exp_mp)) begin errors++; $display("[TB] FAIL b2b_counts: got %0d/%0d exp %0d/%0d", br_count, mispred_count, exp_br, exp_mp); end
    drive_op(BR_BEQ, 1'b0, 1'b0, 32'h300, 32'h8, 32'd3, 32'd3, 1'b1);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir || br_count !== 16'(exp_br)) begin errors++; $display("[TB] FAIL b2b_second: got redir=%b cnt=%0d exp %b/%0d", bus.redir_valid, br_count, e.redir, exp_br); end
  endtask

  task automatic test_jalr();
    drive_op(3'b000, 1'b0, 1'b1, 32'h200, 32'h3, 32'h1001, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir || bus.redir_pc !== e.redir_pc) begin errors++; $display("[TB] FAIL jalr_redir: got %b/%h exp %b/%h", bus.redir_valid, bus.redir_pc, e.redir, e.redir_pc); end
    checks++; if (bus.link_valid !== e.link || bus.link_data !== e.link_data) begin errors++; $display("[TB] FAIL jalr_link: got %b/%h exp %b/%h", bus.link_valid, bus.link_data, e.link, e.link_data); end
    finish_redirect();
    drive_op(3'b000, 1'b1, 1'b0, 32'h600, 32'h100, 32'h0, 32'h0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir || bus.link_valid !== e.link || bus.link_data !== e.link_data) begin errors++; $display("[TB] FAIL jal_pred: got redir=%b link=%b/%h exp %b/%b/%h", bus.redir_valid, bus.link_valid, bus.link_data, e.redir, e.link, e.link_data); end
    @(negedge clk);
    checks++; if (bus.link_valid !== 1'b0) begin errors++; $display("[TB] FAIL jal_link_pulse: got %b exp 0", bus.link_valid); end
  endtask

  task automatic test_misalign();
    drive_op(BR_BLT, 1'b0, 1'b0, 32'h100, 32'h2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (bus.misalign_exc !== e.exc || bus.exc_pc !== e.exc_pc) begin errors++; $display("[TB] FAIL blt_exc: got %b/%h exp %b/%h", bus.misalign_exc, bus.exc_pc, e.exc, e.exc_pc); end
    checks++; if (bus.redir_valid !== e.redir || bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL blt_no_redir: got redir=%b ready=%b exp %b/1", bus.redir_valid, bus.br_ready, e.redir); end
    drive_op(3'b000, 1'b1, 1'b0, 32'h700, 32'h6, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.misalign_exc !== e.exc || bus.link_valid !== e.link || bus.redir_valid !== e.redir) begin errors++; $display("[TB] FAIL jal_misalign: got exc=%b link=%b redir=%b exp %b/%b/%b", bus.misalign_exc, bus.link_valid, bus.redir_valid, e.exc, e.link, e.redir); end
    drive_op(BR_BEQ, 1'b0, 1'b0, 32'h100, 32'h2, 32'd1, 32'd2, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.misalign_exc !== e.exc || mispred_count !== 16'(exp_mp)) begin errors++; $display("[TB] FAIL nt_no_exc: got exc=%b mp=%0d exp %b/%0d", bus.misalign_exc, mispred_count, e.exc, exp_mp); end
  endtask

  task automatic test_redirect_stall();
    int n;
    int guard;
    drive_op(BR_BGEU, 1'b0, 1'b0, 32'h400, 32'h40, 32'hFFFF_FFF0, 32'h1, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir || bus.redir_pc !== e.redir_pc) begin errors++; $display("[TB] FAIL bgeu_redir: got %b/%h exp %b/%h", bus.redir_valid, bus.redir_pc, e.redir, e.redir_pc); end
    bus.br_funct3 = BR_BNE; bus.br_pc = 32'h800; bus.br_rs1 = 32'd1; bus.br_rs2 = 32'd2; bus.br_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.redir_pc !== e.redir_pc || bus.br_ready !== 1'b0 || bus.redir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold_%0d: got pc=%h ready=%b redir=%b exp %h/0/1", i, bus.redir_pc, bus.br_ready, bus.redir_valid, e.redir_pc); end
    end
    bus.br_valid = 1'b0;
    checks++; if (br_count !== 16'(exp_br)) begin errors++; $display("[TB] FAIL stall_ignored: got %0d exp %0d", br_count, exp_br); end
    bus.redir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.redir_ready = 1'b0;
    exp_mp++;
    checks++; if (mispred_count !== 16'(exp_mp)) begin errors++; $display("[TB] FAIL stall_mispred: got %0d exp %0d", mispred_count, exp_mp); end
    n = 0;
    guard = 0;
    while (bus.br_ready !== 1'b1 && guard < 20) begin
      if (bus.flush_ifid === 1'b1) n++;
      @(negedge clk);
      guard++;
    end
    checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_timeout: got ready=%b exp 1", bus.br_ready); end
    checks++; if (n != FLUSH || bus.flush_ifid !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush_len: got %0d cycles flush=%b exp %0d/0", n, bus.flush_ifid, FLUSH); end
  endtask

  task automatic test_reset_mid_redirect();
    drive_op(BR_BEQ, 1'b0, 1'b0, 32'h500, 32'h10, 32'd4, 32'd4, 1'b0);
    e = exp_q.pop_front();
    checks++; if (bus.redir_valid !== e.redir) begin errors++; $display("[TB] FAIL rstmid_redir: got %b exp %b", bus.redir_valid, e.redir); end
    rst = 1'b1;
    bus.redir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.redir_ready = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    checks++; if (bus.br_ready !== 1'b1 || bus.redir_valid !== 1'b0 || bus.flush_ifid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_state: got ready=%b redir=%b flush=%b exp 1/0/0", bus.br_ready, bus.redir_valid, bus.flush_ifid); end
    checks++; if (bus.redir_pc !== 32'h0 || br_count !== 16'(exp_br) || mispred_count !== 16'(exp_mp)) begin errors++; $display("[TB] FAIL rstmid_values: got pc=%h cnt=%0d mp=%0d exp 0/0/0", bus.redir_pc, br_count, mispred_count); end
  endtask

  task automatic test_saturation();
    bus_s.br_funct3 = BR_BNE; bus_s.br_is_jal = 1'b0; bus_s.br_is_jalr = 1'b0;
    bus_s.br_pc = 32'h100; bus_s.br_imm = 32'h10; bus_s.br_rs1 = 32'd9; bus_s.br_rs2 = 32'd9;
    bus_s.br_pred_taken = 1'b0;
    bus_s.br_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sat_q.push_back((i + 1 > 3) ? 2'd3 : 2'(i + 1));
      @(posedge clk);
      @(negedge clk);
      sat_e = sat_q.pop_front();
      checks++; if (s_br_count !== sat_e) begin errors++; $display("[TB] FAIL sat_br_%0d: got %0d exp %0d", i, s_br_count, sat_e); end
    end
    bus_s.br_valid = 1'b0;
    bus_s.br_funct3 = BR_BEQ;
    bus_s.redir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_s.br_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_s.br_valid = 1'b0;
      sat_q.push_back((i + 1 > 3) ? 2'd3 : 2'(i + 1));
      checks++; if (bus_s.redir_valid !== 1'b1 || bus_s.redir_pc !== 32'h110) begin errors++; $display("[TB] FAIL sat_redir_%0d: got %b/%h exp 1/00000110", i, bus_s.redir_valid, bus_s.redir_pc); end
      @(posedge clk);
      @(negedge clk);
      sat_e = sat_q.pop_front();
      checks++; if (bus_s.br_ready !== 1'b1 || bus_s.flush_ifid !== 1'b0) begin errors++; $display("[TB] FAIL sat_noflush_%0d: got ready=%b flush=%b exp 1/0", i, bus_s.br_ready, bus_s.flush_ifid); end
      checks++; if (s_mispred_count !== sat_e) begin errors++; $display("[TB] FAIL sat_mp_%0d: got %0d exp %0d", i, s_mispred_count, sat_e); end
    end
    bus_s.redir_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; exp_br = 0; exp_mp = 0;
    rst = 1'b1;
    bus.br_valid = 1'b0; bus.br_funct3 = 3'b0; bus.br_is_jal = 1'b0; bus.br_is_jalr = 1'b0;
    bus.br_pc = '0; bus.br_imm = '0; bus.br_rs1 = '0; bus.br_rs2 = '0;
    bus.br_pred_taken = 1'b0; bus.redir_ready = 1'b0;
    bus_s.br_valid = 1'b0; bus_s.br_funct3 = 3'b0; bus_s.br_is_jal = 1'b0; bus_s.br_is_jalr = 1'b0;
    bus_s.br_pc = '0; bus_s.br_imm = '0; bus_s.br_rs1 = '0; bus_s.br_rs2 = '0;
    bus_s.br_pred_taken = 1'b0; bus_s.redir_ready = 1'b0;
    test_reset();
    test_beq_mispredict();
    test_back_to_back();
    test_jalr();
    test_misalign();
    test_redirect_stall();
    test_reset_mid_redirect();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
